// File: rtl/arm_pkg.sv
// Shared types and decode helpers for the ARMv4-subset multicycle control path.
package arm_pkg;

    localparam int unsigned ALU_OP_W = 3;
    localparam int unsigned INSTR_W  = 20;
    localparam int unsigned FLAGS_W  = 4;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXECR, EXECI, ALUWB, BRANCH, FAULT
    } state_t;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_ORR   = 3'b011,
        ALU_EOR   = 3'b100,
        ALU_PASSB = 3'b101
    } alu_op_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
        COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
        COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
        COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
    } cond_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    typedef struct packed {
        logic    valid;
        logic    write;
        logic    arith;
        alu_op_t op;
    } dp_dec_t;

    // Data-processing command -> ALU op, whether Rd is written, whether C/V are meaningful.
    function automatic dp_dec_t dp_decode(input logic [3:0] cmd);
        dp_dec_t d;
        d.valid = 1'b1;
        d.write = 1'b1;
        d.arith = 1'b0;
        d.op    = ALU_ADD;
        case (cmd)
            CMD_ADD: d.arith = 1'b1;
            CMD_SUB: begin d.op = ALU_SUB; d.arith = 1'b1; end
            CMD_AND: d.op = ALU_AND;
            CMD_ORR: d.op = ALU_ORR;
            CMD_EOR: d.op = ALU_EOR;
            CMD_MOV: d.op = ALU_PASSB;
            CMD_TST: begin d.op = ALU_AND; d.write = 1'b0; end
            CMD_CMP: begin d.op = ALU_SUB; d.write = 1'b0; d.arith = 1'b1; end
            default: begin d.valid = 1'b0; d.write = 1'b0; end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/arm_condcheck.sv
// Condition-field evaluation against {N,Z,C,V}; purely combinational.
module arm_condcheck
    import arm_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = !z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = !c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = !n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = !v;
            COND_HI: cond_ex = c && !z;
            COND_LS: cond_ex = !c || z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = !z && (n == v);
            COND_LE: cond_ex = z || (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_multi_ctrl.sv
// Multicycle control FSM sequencing a shared instruction/data memory with
// wait-state handshake, condition flags and an optional bus-timeout fault.
module arm_multi_ctrl
    import arm_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 3,
    parameter int unsigned TIMEOUT   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [19:0]          instr,
    input  logic [3:0]           alu_flags,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           reg_src,
    output logic [1:0]           imm_src,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic [1:0]           result_src,
    output logic                 fault
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t           state;
    logic [3:0]       flags;
    logic [CNT_W-1:0] wait_cnt;
    logic             cond_ex;
    logic             waiting;
    logic             timeout_hit;
    alu_op_t          alu_op;
    dp_dec_t          dp;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       unused_rn;

    assign cond      = instr[19:16];
    assign op        = instr[15:14];
    assign funct     = instr[13:8];
    assign rd        = instr[3:0];
    assign unused_rn = ^instr[7:4];

    assign dp = dp_decode(funct[4:1]);

    arm_condcheck u_condcheck (
        .cond    (cond),
        .flags   (flags),
        .cond_ex (cond_ex)
    );

    assign waiting     = mem_req && !mem_ready;
    assign timeout_hit = (TIMEOUT != 0) && waiting && (wait_cnt == CNT_W'(TIMEOUT - 1));

    // State, flags, wait counter and sticky fault.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            flags    <= '0;
            wait_cnt <= '0;
            fault    <= 1'b0;
        end else if (timeout_hit) begin
            state    <= FAULT;
            fault    <= 1'b1;
            wait_cnt <= '0;
        end else begin
            // A waiting cycle never changes state, so any other cycle clears the count.
            wait_cnt <= waiting ? wait_cnt + CNT_W'(1) : '0;
            case (state)
                FETCH:  if (mem_ready) state <= DECODE;
                DECODE: begin
                    if (!cond_ex) begin
                        state <= FETCH;
                    end else begin
                        case (op)
                            OP_MEM:  state <= MEMADR;
                            OP_DP:   state <= funct[5] ? EXECI : EXECR;
                            OP_BR:   state <= BRANCH;
                            default: state <= FETCH;
                        endcase
                    end
                end
                MEMADR: state <= funct[0] ? MEMRD : MEMWR;
                MEMRD:  if (mem_ready) state <= MEMWB;
                MEMWR:  if (mem_ready) state <= FETCH;
                EXECR, EXECI: begin
                    // Compares always set flags; other ops only with S.
                    if (dp.valid && (funct[0] || !dp.write)) begin
                        flags[3:2] <= alu_flags[3:2];
                        if (dp.arith) flags[1:0] <= alu_flags[1:0];
                    end
                    state <= (dp.valid && dp.write) ? ALUWB : FETCH;
                end
                FAULT:   state <= FAULT;
                default: state <= FETCH;
            endcase
        end
    end

    assign reg_src     = {(op == OP_MEM) && !funct[0], op == OP_BR};
    assign alu_control = ALUCTRL_W'(alu_op);

    // Per-state datapath controls; enables are forced low while reset is held.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        imm_src    = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = ALU_ADD;
        result_src = 2'b00;
        case (state)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            DECODE: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMADR: begin
                alu_src_b = 2'b01;
                imm_src   = 2'b01;
            end
            MEMRD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
            end
            EXECR: alu_op = dp.op;
            EXECI: begin
                alu_op    = dp.op;
                alu_src_b = 2'b01;
            end
            ALUWB: begin
                reg_write = 1'b1;
                pc_write  = (rd == 4'd15);
            end
            BRANCH: begin
                alu_src_b  = 2'b01;
                imm_src    = 2'b10;
                result_src = 2'b10;
                pc_write   = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

endmodule
